mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
- MBIST sequencer for one single-port SRAM. Runs March C- over the full address range:
  - M0: ⇕(w0)
  - M1: ⇑(r0,w1)
  - M2: ⇑(r1,w0)
  - M3: ⇓(r0,w1)
  - M4: ⇓(r1,w0)
  - M5: ⇕(r0)
- Owns the up/down address counter.
- Drives the memory port, compares read data and reports pass/fail plus the first failing location.
- Sits between the top-level BIST enable/status register and the memory wrapper's test-mux port.

Parameters:
- ADDR_W, 12, memory address width.
- DEPTH, 4096, number of words tested (addresses 0..DEPTH-1). Must satisfy 2 <= DEPTH <= 2**ADDR_W.
- DATA_W, 8, memory word width. Background pattern is all-zeros or all-ones.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; starts a test from IDLE or DONE
- busy  out  1  high from the cycle after an accepted start until DONE is entered
- done  out  1  high in DONE; held until the next accepted start
- fail  out  1  sticky mismatch flag; cleared on accepted start
- fail_addr  out  ADDR_W  address of the first mismatch
- fail_elem  out  3  March element index (0-5) of the first mismatch
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re

Behaviour:
- Reset values: state IDLE; busy, done, fail, mem_re, mem_we = 0; mem_addr, mem_wdata, fail_addr, fail_elem = 0.
- rst mid-test aborts immediately. No further memory accesses are issued.
- All outputs are registered.
- States: IDLE, INIT, RD, WR, FIN, FLUSH, DONE.
- IDLE/DONE + start -> INIT. Clears done, fail, fail_addr, fail_elem. Address = 0, elem = 0.
- start while busy is ignored.
- INIT (M0):
  - One write per cycle, wdata = 0, address ascending.
  - At DEPTH-1: elem = 1, address = 0, -> RD.
- RD:
  - mem_re = 1; expected value = 0 for M1/M3, all-ones for M2/M4.
  - -> WR next cycle.
- WR:
  - mem_we = 1, wdata = ~expected.
  - mem_rdata is compared to the expected value registered from the RD cycle.
  - Then either step the address (+1 for M1/M2, -1 for M3/M4) and -> RD, or, at the terminal address (DEPTH-1 up / 0 down), advance elem.
  - M1 -> M2 and M3 -> M4 restart at the same end.
  - M2 -> M3 starts at DEPTH-1. M4 -> M5 starts at 0 and -> FIN.
- FIN (M5): one read per cycle, expected 0, address ascending. The compare for the read issued at cycle N happens at N+1. At DEPTH-1 -> FLUSH.
- FLUSH: one cycle; compares the last read, then -> DONE.
- Mismatch:
  - fail set on the compare cycle.
  - fail_addr/fail_elem are captured only if fail was previously 0.
  - A mismatch and element wrap in the same cycle records the element that issued the read.
- Cycle count for a clean run: DEPTH (M0) + 8*DEPTH (M1-M4) + DEPTH (M5) + 1 (FLUSH). DONE is entered on the following cycle.
- Address arithmetic is ADDR_W bits and never wraps: terminal detection precedes the increment or decrement.
- mem_re and mem_we are never asserted together.

Optional Feature:
- Macro: MBIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch forces -> DONE on the following cycle; no further accesses are issued. done = 1, fail = 1.
- Undefined: the test runs to completion regardless of mismatches; only the first failure is recorded.

Decomposition:
- mbist_pkg holds:
  - state enum
  - element index constants M0..M5
  - per-element direction (up/down) and expected-data-polarity lookup functions
  - FAIL_ELEM_W = 3
- Sub-module mbist_addr_gen:
  - ADDR_W-bit loadable up/down counter.
  - Inputs: load, load_val, en, ud. Outputs: q, at_top (q == DEPTH-1), at_bot (q == 0).
  - Synchronous active-high rst.

Test Plan:
- DEPTH=16, fault-free memory model, start pulse -> done after 16+128+16+1 cycles, then DONE cycle; fail=0; access trace matches March C- order and directions.
- Stuck-at-1 on bit 3 of address 5 -> fail=1, fail_addr=5, fail_elem=1.
- Coupling fault (write 1 to address 9 flips address 8), DEPTH=16 -> first mismatch at fail_addr=8, fail_elem=2.
- rst asserted in M3 at address 10 -> next cycle: busy=0, done=0, mem_re=mem_we=0, state IDLE; a new start reruns cleanly.
- start pulsed while busy -> ignored, cycle count unchanged. start in DONE -> done and fail cleared, new run.
- MBIST_STOP_ON_FAIL_EN defined, stuck-at-0 at address 0 -> mismatch on the first M2 read, done 1 cycle later, no accesses afterwards.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and March C- element helpers for the MBIST sequencer.
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD,
    ST_WR,
    ST_FIN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int FAIL_ELEM_W = 3;

  localparam logic [FAIL_ELEM_W-1:0] M0 = 3'd0;
  localparam logic [FAIL_ELEM_W-1:0] M1 = 3'd1;
  localparam logic [FAIL_ELEM_W-1:0] M2 = 3'd2;
  localparam logic [FAIL_ELEM_W-1:0] M3 = 3'd3;
  localparam logic [FAIL_ELEM_W-1:0] M4 = 3'd4;
  localparam logic [FAIL_ELEM_W-1:0] M5 = 3'd5;

  // Only M3/M4 walk downwards; the rest ascend.
  function automatic logic elem_up(input logic [FAIL_ELEM_W-1:0] e);
    return !((e == M3) || (e == M4));
  endfunction

  // M2/M4 read back the all-ones background written by the previous element.
  function automatic logic elem_exp_ones(input logic [FAIL_ELEM_W-1:0] e);
    return (e == M2) || (e == M4);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter with terminal-address flags.
module mbist_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              ud,
  output logic [ADDR_W-1:0] q,
  output logic              at_top,
  output logic              at_bot
);

  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= ud ? q + ADDR_W'(1) : q - ADDR_W'(1);
    end
  end

  assign at_top = (q == ADDR_TOP);
  assign at_bot = (q == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer for a single-port SRAM.
// Optional MBIST_STOP_ON_FAIL_EN: jump to DONE on the first mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [FAIL_ELEM_W-1:0] fail_elem,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

  state_e                 state, state_n;
  logic [FAIL_ELEM_W-1:0] elem, elem_n;
  logic                   ld, en, ud, at_top, at_bot, accept, mismatch;
  logic [ADDR_W-1:0]      ld_val, addr_q;
  logic [DATA_W-1:0]      wdata_n;

  logic                   vld_p1;
  logic [DATA_W-1:0]      exp_p1;
  logic [ADDR_W-1:0]      addr_p1;
  logic [FAIL_ELEM_W-1:0] elem_p1;

  mbist_addr_gen #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .load_val(ld_val),
    .en      (en),
    .ud      (ud),
    .q       (addr_q),
    .at_top  (at_top),
    .at_bot  (at_bot)
  );

  assign mem_addr = addr_q;

  // Compare only in states that follow a read; DONE may still see a stale read after a stop.
  always_comb begin
    mismatch = vld_p1 && (mem_rdata != exp_p1) &&
               ((state == ST_WR) || (state == ST_FIN) || (state == ST_FLUSH));
  end

  always_comb begin
    state_n = state;
    elem_n  = elem;
    ld      = 1'b0;
    ld_val  = '0;
    en      = 1'b0;
    ud      = 1'b1;
    accept  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ST_INIT;
          elem_n  = M0;
          ld      = 1'b1;
        end
      end
      ST_INIT: begin
        if (at_top) begin
          elem_n  = M1;
          ld      = 1'b1;
          state_n = ST_RD;
        end else begin
          en = 1'b1;
        end
      end
      ST_RD: state_n = ST_WR;
      ST_WR: begin
        ud      = elem_up(elem);
        state_n = ST_RD;
        if (!(ud ? at_top : at_bot)) begin
          en = 1'b1;
        end else begin
          ld = 1'b1;
          case (elem)
            M1: elem_n = M2;
            M2: begin
              elem_n = M3;
              ld_val = ADDR_TOP;
            end
            M3: begin
              elem_n = M4;
              ld_val = ADDR_TOP;
            end
            default: begin
              elem_n  = M5;
              state_n = ST_FIN;
            end
          endcase
        end
      end
      ST_FIN: begin
        if (at_top) state_n = ST_FLUSH;
        else        en = 1'b1;
      end
      ST_FLUSH: state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
`ifdef MBIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_n = ST_DONE;
      ld      = 1'b0;
      en      = 1'b0;
    end
`endif
  end

  always_comb begin
    wdata_n = '0;
    if ((state_n == ST_WR) && !elem_exp_ones(elem_n)) wdata_n = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      elem      <= M0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      elem      <= elem_n;
      busy      <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done      <= (state_n == ST_DONE);
      mem_re    <= (state_n == ST_RD) || (state_n == ST_FIN);
      mem_we    <= (state_n == ST_INIT) || (state_n == ST_WR);
      mem_wdata <= wdata_n;
    end
  end

  // Stage p1: context of the read issued last cycle, lined up with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= mem_re;
  end

  always_ff @(posedge clk) begin
    exp_p1  <= elem_exp_ones(elem) ? '1 : '0;
    addr_p1 <= addr_q;
    elem_p1 <= elem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (accept) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_addr <= addr_p1;
        fail_elem <= elem_p1;
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl on a 16-word memory model with injectable faults.
module tb_mbist_march_ctrl;

  localparam int AW   = 4;
  localparam int D    = 16;
  localparam int DW   = 8;
  localparam int NCYC = 10 * D + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fail, mem_re, mem_we;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [D];
  int            fault_mode = 0;  // 0 none, 1 SA1 a5 b3, 2 coupling 9->8, 3 SA0 a0 b0
  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   trace [$];

  mbist_march_ctrl #(
    .ADDR_W(AW),
    .DEPTH (D),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_fault(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (fault_mode == 1 && a == 4'd5) r = d | 8'h08;
    if (fault_mode == 3 && a == 4'd0) r = d & 8'hFE;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (fault_mode == 2 && mem_addr == 4'd9 && mem_wdata == 8'hFF) mem[8] <= ~mem[8];
    end
    if (mem_re) mem_rdata <= rd_fault(mem_addr, mem[mem_addr]);
  end

  function automatic logic [31:0] pack(input logic b, input logic r, input logic w,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {17'b0, b, r, w, (r | w) ? a : 4'h0, w ? d : 8'h00};
  endfunction

  function automatic logic [31:0] now_pack();
    return pack(busy, mem_re, mem_we, mem_addr, mem_wdata);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
  endtask

  // Expected March C- access sequence, one entry per busy cycle.
  task automatic build_trace();
    logic [DW-1:0] bg;
    logic [AW-1:0] a;
    trace.delete();
    for (int i = 0; i < D; i++) trace.push_back(pack(1'b1, 1'b0, 1'b1, AW'(i), 8'h00));
    for (int e = 1; e <= 4; e++) begin
      bg = (e == 2 || e == 4) ? 8'hFF : 8'h00;
      for (int i = 0; i < D; i++) begin
        a = (e < 3) ? AW'(i) : AW'(D - 1 - i);
        trace.push_back(pack(1'b1, 1'b1, 1'b0, a, 8'h00));
        trace.push_back(pack(1'b1, 1'b0, 1'b1, a, ~bg));
      end
    end
    for (int i = 0; i < D; i++) trace.push_back(pack(1'b1, 1'b1, 1'b0, AW'(i), 8'h00));
    trace.push_back(pack(1'b1, 1'b0, 1'b0, 4'h0, 8'h00));
  endtask

  task automatic clean_run(input string tag);
    fault_mode = 0;
    do_start();
    for (int i = 0; i < trace.size(); i++) begin
      chk({tag, "_trace"}, now_pack(), trace[i]);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_idle_port"}, 32'({mem_re, mem_we}), 32'd0);
  endtask

  task automatic fault_run(input string tag, input int mode, input int exp_n,
                           input int exp_addr, input int exp_elem);
    int n;
    fault_mode = mode;
    do_start();
    run_to_done(n);
    chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_fail"}, 32'(fail), 32'd1);
    chk({tag, "_fail_addr"}, 32'(fail_addr), 32'(exp_addr));
    chk({tag, "_fail_elem"}, 32'(fail_elem), 32'(exp_elem));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < D; i++) mem[i] = '0;
    build_trace();

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_port", 32'({mem_re, mem_we, mem_addr, mem_wdata}), 32'd0);
    chk("rst_fail_loc", 32'({fail_addr, fail_elem}), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_quiet", now_pack(), 32'd0);

    clean_run("clean");

`ifdef MBIST_STOP_ON_FAIL_EN
    fault_run("sa1", 1, 28, 5, 1);
`else
    fault_run("sa1", 1, NCYC, 5, 1);
`endif

    // Restart from DONE with fail set, on a now fault-free memory.
    fault_mode = 0;
    do_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_fail", 32'({fail, fail_addr, fail_elem}), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    run_to_done(n);
    chk("restart_cycles", 32'(n), 32'(NCYC - 0));
    chk("restart_clean", 32'(fail), 32'd0);

`ifdef MBIST_STOP_ON_FAIL_EN
    fault_run("couple", 2, 66, 8, 2);
`else
    fault_run("couple", 2, NCYC, 8, 2);
`endif

    // start pulsed mid-run must not restart the sequence.
    fault_mode = 0;
    do_start();
    n = 0;
    while (!done && n < 2000) begin
      start = (n == 20);
      tick();
      n++;
    end
    start = 1'b0;
    chk("busy_start_cycles", 32'(n), 32'(NCYC));

    // Reset while M3 is reading address 10.
    do_start();
    repeat (90) tick();
    chk("m3_a10", now_pack(), pack(1'b1, 1'b1, 1'b0, 4'd10, 8'h00));
    rst = 1'b1;
    tick();
    chk("abort_state", 32'({busy, done, mem_re, mem_we}), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_quiet", 32'({busy, done, mem_re, mem_we}), 32'd0);
    clean_run("rerun");

`ifdef MBIST_STOP_ON_FAIL_EN
    fault_run("sa0", 3, 50, 0, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stop_quiet", 32'({done, mem_re, mem_we}), 32'b100);
    end
`else
    fault_run("sa0", 3, NCYC, 0, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
